// File: rtl/period_meter.sv
// Period meter: recovers the period (and, with HIGH_TIME_EN defined, the high time) of a
// periodic input in clk cycles, measuring back-to-back periods rising edge to rising edge.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic                   s, rise;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   cnt_at_max;

    assign s          = sync_q[SYNC_STAGES-1];
    assign rise       = s & ~s_d_q;
    assign cnt_at_max = (cnt_q == CNT_MAX);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_d_d      = s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        // Dropping en wins over a rise in the same cycle; the partial period is lost.
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d   = cnt_q;
                        valid_d    = 1'b1;
                        overflow_d = 1'b0;
                        cnt_d      = CNT_ONE;
                    end else if (cnt_at_max) begin
                        // No edge within the counter range: flag it and re-arm from scratch.
                        overflow_d = 1'b1;
                        state_d    = ARM;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            sync_q     <= '0;
            s_d_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            s_d_q      <= s_d_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef HIGH_TIME_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // hcnt counts cycles with s=1 since the last rise; s cannot return high without a new rise.
    always_comb begin
        hcnt_d      = hcnt_q;
        high_time_d = high_time_q;
        if (!en || state_q == IDLE) begin
            hcnt_d = '0;
        end else if (rise && (state_q == ARM || state_q == MEASURE)) begin
            hcnt_d = CNT_ONE;
            if (state_q == MEASURE) begin
                high_time_d = hcnt_q;
            end
        end else if (state_q == MEASURE) begin
            if (cnt_at_max) begin
                hcnt_d = '0;
            end else if (s) begin
                hcnt_d = sat_inc(hcnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            hcnt_q      <= '0;
            high_time_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance for the main scenarios and an 8-bit
// instance for counter saturation.
module tb_period_meter;

    logic        clk = 1'b0;
    logic        preset;
    logic        en, sig_in;
    logic [15:0] period, high_time;
    logic        valid, overflow, busy;

    logic        en8, sig8;
    logic [7:0]  period8, high_time8;
    logic        valid8, overflow8, busy8;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int qp[$];
    int qh[$];
    int qt[$];
    int q8[$];

    always #5 clk = ~clk;

    period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .preset(preset), .en(en), .sig_in(sig_in),
        .period(period), .high_time(high_time), .valid(valid),
        .overflow(overflow), .busy(busy)
    );

    period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .preset(preset), .en(en8), .sig_in(sig8),
        .period(period8), .high_time(high_time8), .valid(valid8),
        .overflow(overflow8), .busy(busy8)
    );

    function automatic int hexp(input int h);
`ifdef HIGH_TIME_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then drive the next sig_in value.
    task automatic step(input logic s);
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            qp.push_back(int'(period));
            qh.push_back(int'(high_time));
            qt.push_back(cyc);
        end
        sig_in = s;
    endtask

    task automatic chunk(input int p, input int h);
        for (int i = 0; i < p; i++) step(i < h);
    endtask

    task automatic step8(input logic s);
        @(negedge clk);
        if (valid8 === 1'b1) q8.push_back(int'(period8));
        sig8 = s;
    endtask

    task automatic chunk8(input int p, input int h);
        for (int i = 0; i < p; i++) step8(i < h);
    endtask

    task automatic qclear();
        qp.delete();
        qh.delete();
        qt.delete();
    endtask

    task automatic restart();
        en = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0);
        en = 1'b1;
        step(1'b0);
        step(1'b0);
        qclear();
    endtask

    initial begin
        preset = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        en8    = 1'b0;
        sig8   = 1'b0;
        repeat (10) @(negedge clk);

        // Reset state
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf8", overflow8, 0);
        check("rst_busy8", busy8, 0);

        preset = 1'b1;
        en     = 1'b1;
        en8    = 1'b1;

        // Test 1: square wave period 10, high 5
        qclear();
        for (int k = 0; k < 4; k++) chunk(10, 5);
        for (int k = 0; k < 4; k++) step(1'b0);
        check("t1_count", qp.size(), 3);
        for (int i = 0; i < qp.size(); i++) begin
            check("t1_period", qp[i], 10);
            check("t1_high", qh[i], hexp(5));
        end
        if (qt.size() == 3) begin
            check("t1_spacing_a", qt[1] - qt[0], 10);
            check("t1_spacing_b", qt[2] - qt[1], 10);
        end
        check("t1_busy", busy, 1);
        check("t1_ovf", overflow, 0);

        // Test 6: back-to-back 10 -> 37 -> 2
        restart();
        chunk(10, 5);
        chunk(10, 5);
        chunk(37, 18);
        chunk(2, 1);
        chunk(5, 2);
        for (int k = 0; k < 4; k++) step(1'b0);
        check("t6_count", qp.size(), 4);
        if (qp.size() == 4) begin
            check("t6_p0", qp[0], 10);
            check("t6_p1", qp[1], 10);
            check("t6_p2", qp[2], 37);
            check("t6_p3", qp[3], 2);
            check("t6_h2", qh[2], hexp(18));
            check("t6_h3", qh[3], hexp(1));
        end

        // Test 2: generator carry pulse, period 113, high 1
        restart();
        for (int k = 0; k < 4; k++) chunk(113, 1);
        for (int k = 0; k < 4; k++) step(1'b0);
        check("t2_count", qp.size(), 3);
        for (int i = 0; i < qp.size(); i++) begin
            check("t2_period", qp[i], 113);
            check("t2_high", qh[i], hexp(1));
        end
        check("t2_ovf", overflow, 0);

        // Test 4: en dropped in the same cycle the rise reaches the FSM
        restart();
        chunk(12, 6);
        chunk(12, 6);
        for (int k = 0; k < 4; k++) step(1'b0);
        check("t4_pre_count", qp.size(), 1);
        if (qp.size() == 1) check("t4_pre_period", qp[0], 12);
        qclear();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        en = 1'b0;
        step(1'b1);
        step(1'b1);
        for (int k = 0; k < 4; k++) step(1'b0);
        check("t4_no_valid", qp.size(), 0);
        check("t4_busy", busy, 0);
        check("t4_period_hold", period, 12);
        en = 1'b1;
        chunk(9, 4);
        chunk(9, 4);
        for (int k = 0; k < 4; k++) step(1'b0);
        check("t4_rearm_count", qp.size(), 1);
        if (qp.size() == 1) check("t4_rearm_period", qp[0], 9);

        // Test 3: 8-bit saturation, then recovery at period 20
        q8.delete();
        step8(1'b1);
        for (int k = 1; k <= 256; k++) step8(k < 3);
        step8(1'b0);
        check("t3_ovf_before", overflow8, 0);
        check("t3_busy_before", busy8, 1);
        step8(1'b0);
        check("t3_ovf_set", overflow8, 1);
        check("t3_busy_arm", busy8, 0);
        chunk8(20, 10);
        check("t3_first_rise_nv", q8.size(), 0);
        check("t3_ovf_sticky", overflow8, 1);
        chunk8(20, 10);
        for (int k = 0; k < 5; k++) step8(1'b0);
        check("t3_count", q8.size(), 1);
        if (q8.size() == 1) check("t3_period", q8[0], 20);
        check("t3_ovf_clr", overflow8, 0);

        // Test 5: asynchronous reset in the middle of a measurement
        restart();
        chunk(10, 5);
        chunk(10, 5);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("t5_busy_pre", busy, 1);
        check("t5_period_pre", period, 10);
        @(posedge clk);
        #3 preset = 1'b0;
        #1;
        check("t5_period_async", period, 0);
        check("t5_high_async", high_time, 0);
        check("t5_busy_async", busy, 0);
        check("t5_valid_async", valid, 0);
        check("t5_ovf_async", overflow, 0);
        qclear();
        for (int k = 0; k < 3; k++) step(1'b0);
        preset = 1'b1;
        chunk(10, 5);
        for (int k = 0; k < 5; k++) step(1'b0);
        check("t5_no_spurious", qp.size(), 0);
        check("t5_period_after", period, 0);
        check("t5_busy_after", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
